// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and the golden-function helper for the truth-table sequencer.
// Optional build macro STOP_ON_FAIL_EN is consumed by the top module only.
package tt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // Widest vector the helper reduces over; only the low n bits take part.
    localparam int VEC_MAX = 8;

    function automatic logic expect_bit(input logic [2:0] op,
                                        input logic [VEC_MAX-1:0] vec,
                                        input int unsigned n);
        logic r_and;
        logic r_or;
        logic r_xor;
        logic res;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int unsigned i = 0; i < VEC_MAX; i++) begin
            if (i < n) begin
                r_and = r_and & vec[i];
                r_or  = r_or  | vec[i];
                r_xor = r_xor ^ vec[i];
            end
        end
        case (op)
            OP_AND:  res = r_and;
            OP_OR:   res = r_or;
            OP_XOR:  res = r_xor;
            OP_NAND: res = ~r_and;
            OP_NOR:  res = ~r_or;
            OP_XNOR: res = ~r_xor;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_golden.sv
// Combinational golden reference: expected gate output for one input vector.
module tt_golden_ref
    import tt_seq_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] vec_i,
    input  logic [2:0]      op_i,
    output logic            exp_y_o
);

    assign exp_y_o = expect_bit(op_i, VEC_MAX'(vec_i), N_IN);

endmodule

// File: rtl/truth_table_sequencer.sv
// Clocked truth-table sweep and checker for small combinational gate DUTs.
// Build macro STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
//
// state  | meaning
// IDLE   | waiting for start after reset
// DRIVE  | dut_in held stable while hold_cnt counts the settle time
// SAMPLE | one cycle after the capture edge; pick next vector or finish
// DONE   | results held; start begins a fresh sweep
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int EXPECT_OP   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            sample_valid,
    output logic [N_IN-1:0] sample_vec,
    output logic            sample_y
);

`ifdef STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [N_IN:0] ERR_MAX  = (N_IN+1)'(1 << N_IN);
    localparam logic [7:0]    HOLD_TC  = 8'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [7:0]        hold_q, hold_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              fail_seen_q, fail_seen_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              sv_q, sv_d;
    logic [N_IN-1:0]   svec_q, svec_d;
    logic              sy_q, sy_d;
    logic              exp_y;

    tt_golden_ref #(.N_IN(N_IN)) u_golden (
        .vec_i   (dut_in_q),
        .op_i    (3'(EXPECT_OP)),
        .exp_y_o (exp_y)
    );

    // Flag an unsupported golden function code in simulation.
    always_comb begin
        assert (EXPECT_OP >= 0 && EXPECT_OP <= 5);
    end

    // State and result registers; reset clears every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dut_in_q    <= '0;
            hold_q      <= '0;
            err_q       <= '0;
            ffv_q       <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
            sv_q        <= 1'b0;
            svec_q      <= '0;
            sy_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dut_in_q    <= dut_in_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            ffv_q       <= ffv_d;
            fail_seen_q <= fail_seen_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
            sv_q        <= sv_d;
            svec_q      <= svec_d;
            sy_q        <= sy_d;
        end
    end

    // Next-state and output decode for the sweep.
    always_comb begin
        state_d     = state_q;
        dut_in_d    = dut_in_q;
        hold_d      = hold_q;
        err_d       = err_q;
        ffv_d       = ffv_q;
        fail_seen_d = fail_seen_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        sv_d        = 1'b0;
        svec_d      = svec_q;
        sy_d        = sy_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // done follows DONE one edge late so it lines up with the
                // published latency, but drops on the restart edge itself.
                done_d = (state_q == ST_DONE);
                if (start) begin
                    done_d      = 1'b0;
                    err_d       = '0;
                    ffv_d       = '0;
                    fail_seen_d = 1'b0;
                    pass_d      = 1'b0;
                    dut_in_d    = '0;
                    hold_d      = '0;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                hold_d = hold_q + 8'd1;
                if (hold_q == HOLD_TC) begin
                    state_d = ST_SAMPLE;
                    sv_d    = 1'b1;
                    svec_d  = dut_in_q;
                    sy_d    = dut_y;
                    // Case inequality so an X/Z from the DUT is a mismatch.
                    if (dut_y !== exp_y) begin
                        if (err_q != ERR_MAX) err_d = err_q + (N_IN+1)'(1);
                        if (!fail_seen_q) begin
                            ffv_d       = dut_in_q;
                            fail_seen_d = 1'b1;
                        end
                    end
                end
            end
            ST_SAMPLE: begin
                if ((STOP_ON_FAIL && fail_seen_q) || (&dut_in_q)) begin
                    state_d = ST_DONE;
                    pass_d  = (err_q == '0);
                end else begin
                    dut_in_d = dut_in_q + N_IN'(1);
                    hold_d   = '0;
                    state_d  = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dut_in         = dut_in_q;
    assign busy           = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;
    assign sample_valid   = sv_q;
    assign sample_vec     = svec_q;
    assign sample_y       = sy_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer (AND instance + XOR instance).
module tb_truth_table_sequencer;

`ifdef STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    localparam int M_GOOD   = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] dut_in;
    logic       dut_y;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic       sample_valid;
    logic [2:0] sample_vec;
    logic       sample_y;

    logic       x_start;
    logic [2:0] x_dut_in;
    logic       x_dut_y;
    logic       x_busy, x_done, x_pass;
    logic [3:0] x_err_count;
    logic [2:0] x_ffv;
    logic       x_sample_valid;
    logic [2:0] x_sample_vec;
    logic       x_sample_y;

    int mode;
    int checks   = 0;
    int failures = 0;
    int x_samples = 0;

    typedef struct {
        logic [2:0] vec;
        logic       y;
    } sample_t;
    sample_t sb[$];

    typedef struct {
        int mode;
        int mid_start;
        int exp_pass;
        int exp_err;
        int exp_ffv;
        int exp_edges;
        int exp_last_vec;
    } row_t;
    row_t rows[4];

    always #5 clk = ~clk;

    truth_table_sequencer #(.N_IN(3), .HOLD_CYCLES(4), .EXPECT_OP(0)) u_and (
        .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(first_fail_vec), .sample_valid(sample_valid),
        .sample_vec(sample_vec), .sample_y(sample_y)
    );

    truth_table_sequencer #(.N_IN(3), .HOLD_CYCLES(1), .EXPECT_OP(2)) u_xor (
        .clk(clk), .rst(rst), .start(x_start), .dut_in(x_dut_in), .dut_y(x_dut_y),
        .busy(x_busy), .done(x_done), .pass(x_pass), .err_count(x_err_count),
        .first_fail_vec(x_ffv), .sample_valid(x_sample_valid),
        .sample_vec(x_sample_vec), .sample_y(x_sample_y)
    );

    function automatic logic model_y(input int m, input logic [2:0] v);
        if (m == M_STUCK0) return 1'b0;
        if (m == M_STUCK1) return 1'b1;
        return &v;
    endfunction

    always_comb dut_y = model_y(mode, dut_in);
    assign x_dut_y = ^x_dut_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sample_unexpected actual_vec=%0d required=none", sample_vec);
            end else begin
                sample_t e;
                e = sb.pop_front();
                chk("sample_vec", int'(sample_vec), int'(e.vec));
                chk("sample_y", int'(sample_y), int'(e.y));
            end
        end
        if (!rst && x_sample_valid) x_samples++;
    end

    task automatic push_expected(input int m);
        for (int v = 0; v < 8; v++) begin
            sample_t s;
            s.vec = 3'(v);
            s.y   = model_y(m, s.vec);
            sb.push_back(s);
            if (STOP && (s.y != (&s.vec))) break;
        end
    endtask

    task automatic run_row(input row_t r);
        int edges;
        mode = r.mode;
        push_expected(r.mode);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_done_low", int'(done), 0);
        chk("start_err_cleared", int'(err_count), 0);
        chk("start_dut_in", int'(dut_in), 0);
        edges = 0;
        do begin
            start = (r.mid_start != 0) && (edges + 1 == r.mid_start);
            @(posedge clk);
            edges++;
            #1;
        end while (!done && edges < 200);
        start = 1'b0;
        chk("done_edge", edges, r.exp_edges);
        chk("pass", int'(pass), r.exp_pass);
        chk("err_count", int'(err_count), r.exp_err);
        chk("first_fail_vec", int'(first_fail_vec), r.exp_ffv);
        chk("final_dut_in", int'(dut_in), r.exp_last_vec);
        chk("busy_after_done", int'(busy), 0);
        chk("scoreboard_left", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        x_start = 1'b0;
        mode = M_GOOD;

        rows[0] = '{M_GOOD,   13, 1, 0, 0, 41, 7};
        rows[1] = '{M_STUCK0,  0, 0, 1, 7, 41, 7};
        if (STOP) rows[2] = '{M_STUCK1, 0, 0, 1, 0, 6, 0};
        else      rows[2] = '{M_STUCK1, 0, 0, 7, 0, 41, 7};
        rows[3] = '{M_GOOD,    0, 1, 0, 0, 41, 7};

        #23;
        chk("rst_dut_in", int'(dut_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_ffv", int'(first_fail_vec), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_row(rows[i]);

        // Reset in the middle of the DRIVE phase of vector 5.
        mode = M_GOOD;
        push_expected(M_GOOD);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (dut_in != 3'd5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_vec5_in_budget", int'(n < 200), 1);
        chk("vec5_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dut_in", int'(dut_in), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_pass", int'(pass), 0);
        chk("arst_err", int'(err_count), 0);
        chk("arst_ffv", int'(first_fail_vec), 0);
        chk("arst_sample_valid", int'(sample_valid), 0);
        chk("arst_sample_vec", int'(sample_vec), 0);
        chk("arst_sample_y", int'(sample_y), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        run_row(rows[3]);

        // XOR instance with a one-cycle hold.
        x_samples = 0;
        @(negedge clk);
        x_start = 1'b1;
        @(posedge clk);
        #1;
        x_start = 1'b0;
        n = 0;
        while (!x_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("xor_done_edge", n, 17);
        chk("xor_pass", int'(x_pass), 1);
        chk("xor_err", int'(x_err_count), 0);
        chk("xor_samples", x_samples, 8);
        chk("xor_last_vec", int'(x_dut_in), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
